risc_ctrl_fsm: RTL

- Multi-cycle control sequencer for the RiSC-16 datapath.
- Drives the ALU one-hot controls (ADD, NAND, PASS1, EQ) and consumes the ALU eq_out flag.
- Holds the instruction register, sequences fetch/decode/execute/memory/writeback with a ready-based memory handshake, and drives all PC, register-file and mux enables.

---
 rtl/risc_ctrl_pkg.sv | 40 ++++
 rtl/risc_ctrl_decode.sv | 85 ++++++++
 rtl/risc_ctrl_fsm.sv | 123 ++++++++++++
 3 files changed

// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RiSC-16 control sequencer and its datapath (ALU, muxes).
package risc_ctrl_pkg;

  // Instruction opcodes, ir[15:13]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // PC next-value select
  localparam logic [1:0] PCS_INC    = 2'd0;  // PC+1
  localparam logic [1:0] PCS_BRANCH = 2'd1;  // PC+1+sext(imm7)
  localparam logic [1:0] PCS_REG    = 2'd2;  // regB

  // Register-file write data select
  localparam logic [1:0] WDS_ALU = 2'd0;
  localparam logic [1:0] WDS_MEM = 2'd1;
  localparam logic [1:0] WDS_PC1 = 2'd2;

  // ALU second operand select
  localparam logic [1:0] SRC2_REG   = 2'd0;
  localparam logic [1:0] SRC2_IMM7  = 2'd1;
  localparam logic [1:0] SRC2_IMM10 = 2'd2;

endpackage

// File: rtl/risc_ctrl_decode.sv
// Control decode: maps the sequencer state and opcode onto every datapath strobe and mux select.
module risc_ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [2:0] op_i,
  input  logic       eq_out_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_sel_o,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       rf_we_o,
  output logic [1:0] rf_wdata_sel_o,
  output logic [1:0] alu_src2_sel_o,
  output logic       add_o,
  output logic       nand_o,
  output logic       pass1_o,
  output logic       eq_o,
  output logic       halted_o
);

  // Everything follows from state/opcode, except two unavoidable single-cycle decisions:
  // the BEQ target select depends on the ALU compare in EXEC, and the SW retire strobe
  // must fire only in the MEM cycle where the memory accepts, so PC moves exactly once.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    pc_we_o        = 1'b0;
    pc_src_o       = PCS_INC;
    rf_we_o        = 1'b0;
    rf_wdata_sel_o = WDS_ALU;
    alu_src2_sel_o = SRC2_REG;
    add_o          = 1'b0;
    nand_o         = 1'b0;
    pass1_o        = 1'b0;
    eq_o           = 1'b0;
    halted_o       = 1'b0;

    // ALU operation is held from EXEC through MEM/WB so results and addresses stay stable
    if (state_i == ST_EXEC || state_i == ST_MEM || state_i == ST_WB) begin
      case (op_i)
        OP_ADD:  add_o = 1'b1;
        OP_ADDI: begin add_o = 1'b1; alu_src2_sel_o = SRC2_IMM7; end
        OP_NAND: nand_o = 1'b1;
        OP_LUI:  begin pass1_o = 1'b1; alu_src2_sel_o = SRC2_IMM10; end
        OP_SW,
        OP_LW:   begin add_o = 1'b1; alu_src2_sel_o = SRC2_IMM7; end
        OP_BEQ:  eq_o = 1'b1;
        default: ;
      endcase
    end

    case (state_i)
      ST_FETCH: mem_req_o = 1'b1;
      ST_EXEC: begin
        if (op_i == OP_BEQ) begin
          pc_we_o  = 1'b1;
          pc_src_o = eq_out_i ? PCS_BRANCH : PCS_INC;
        end else if (op_i == OP_JALR) begin
          rf_we_o        = 1'b1;
          rf_wdata_sel_o = WDS_PC1;
          pc_we_o        = 1'b1;
          pc_src_o       = PCS_REG;
        end
      end
      ST_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (op_i == OP_SW);
        pc_we_o        = (op_i == OP_SW) && mem_ready_i;
      end
      ST_WB: begin
        rf_we_o        = 1'b1;
        pc_we_o        = 1'b1;
        rf_wdata_sel_o = (op_i == OP_LW) ? WDS_MEM : WDS_ALU;
      end
      ST_HALT: halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle RiSC-16 control sequencer: instruction register, idle hold and state sequencing.
//
//   state  | meaning
//   IDLE   | post-reset hold for RESET_PC_HOLD cycles, no strobes
//   FETCH  | instruction read at PC, waits for mem_ready, loads ir
//   DECODE | one quiet cycle, picks EXEC or HALT
//   EXEC   | ALU op; BEQ/JALR update PC (and link reg) here and retire
//   MEM    | LW/SW data access at ALU address; SW retires on mem_ready
//   WB     | register write-back and PC+1
//   HALT   | terminal until reset, halted=1
module risc_ctrl_fsm
  import risc_ctrl_pkg::*;
#(
  parameter int HALT_ON_JALR_IMM = 1,
  parameter int RESET_PC_HOLD    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        eq_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [15:0] ir,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  rf_wdata_sel,
  output logic [1:0]  alu_src2_sel,
  output logic        ADD,
  output logic        NAND,
  output logic        PASS1,
  output logic        EQ,
  output logic        halted
);

  localparam logic [1:0] HOLD_LAST = 2'(RESET_PC_HOLD - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  idle_cnt_q, idle_cnt_d;
  logic [2:0]  op;

  assign op = ir_q[15:13];
  assign ir = ir_q;

  // Next-state, instruction capture and idle-hold counting
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_cnt_q == HOLD_LAST) begin
          state_d    = ST_FETCH;
          idle_cnt_d = 2'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 2'd1;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op == OP_JALR && HALT_ON_JALR_IMM != 0 && ir_q[6:0] != 7'd0)
          state_d = ST_HALT;
        else
          state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op)
          OP_BEQ, OP_JALR: state_d = ST_FETCH;
          OP_LW, OP_SW:    state_d = ST_MEM;
          default:         state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (op == OP_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any instruction in flight immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ir_q       <= 16'h0000;
      idle_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  risc_ctrl_decode u_decode (
    .state_i        (state_q),
    .op_i           (op),
    .eq_out_i       (eq_out),
    .mem_ready_i    (mem_ready),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_sel_o (mem_addr_sel),
    .pc_we_o        (pc_we),
    .pc_src_o       (pc_src),
    .rf_we_o        (rf_we),
    .rf_wdata_sel_o (rf_wdata_sel),
    .alu_src2_sel_o (alu_src2_sel),
    .add_o          (ADD),
    .nand_o         (NAND),
    .pass1_o        (PASS1),
    .eq_o           (EQ),
    .halted_o       (halted)
  );

endmodule
